// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the register-file command controller: default
// command codes, FSM state encoding and timeout counter sizing.
package sys_ctrl_pkg;

  localparam logic [7:0]  WR_CMD_DEF     = 8'hAA;
  localparam logic [7:0]  RD_CMD_DEF     = 8'hBB;
  localparam int unsigned TMO_CYCLES_DEF = 1024;
  localparam int unsigned TMO_CNT_W      = $clog2(TMO_CYCLES_DEF);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ADDR = 3'd1;
  localparam logic [2:0] ST_WR_DATA = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_TX_HOLD = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_WR_ADDR = ST_WR_ADDR,
    S_WR_DATA = ST_WR_DATA,
    S_RD_ADDR = ST_RD_ADDR,
    S_RD_WAIT = ST_RD_WAIT,
    S_TX_HOLD = ST_TX_HOLD
  } sc_state_e;

  // Counter width for a given timeout; never narrower than one bit.
  function automatic int unsigned tmo_cnt_w(input int unsigned tmo);
    return (tmo < 2) ? 1 : $clog2(tmo);
  endfunction

endpackage

// File: rtl/sys_ctrl_rf_if.sv
// Bundle of UART RX/TX and register-file port signals seen by the
// command controller (slave) and its environment (master).
interface sys_ctrl_rf_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] RX_P_DATA;
  logic             RX_D_VLD;
  logic [WIDTH-1:0] RF_RdData;
  logic             RF_Rd_Data_Valid;
  logic             TX_BUSY;
  logic [WIDTH-1:0] RF_Addr;
  logic [WIDTH-1:0] RF_WrData;
  logic             RF_Wr_en;
  logic             RF_Rd_en;
  logic [WIDTH-1:0] TX_P_DATA;
  logic             TX_D_VLD;
  logic             CMD_ERR;
  logic [2:0]       state_dbg;

  // TX handshake: TX_D_VLD is the request and !TX_BUSY the ready; a byte moves
  // in a cycle with TX_D_VLD=1 and TX_BUSY=0, and TX_P_DATA is stable until then.
  modport master (
    output RX_P_DATA, RX_D_VLD, RF_RdData, RF_Rd_Data_Valid, TX_BUSY,
    input  RF_Addr, RF_WrData, RF_Wr_en, RF_Rd_en, TX_P_DATA, TX_D_VLD,
           CMD_ERR, state_dbg
  );

  modport slave (
    input  RX_P_DATA, RX_D_VLD, RF_RdData, RF_Rd_Data_Valid, TX_BUSY,
    output RF_Addr, RF_WrData, RF_Wr_en, RF_Rd_en, TX_P_DATA, TX_D_VLD,
           CMD_ERR, state_dbg
  );
endinterface

// File: rtl/sys_ctrl_frame_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled and pulses expire
// on the TMO_CYCLES-th consecutive cycle without a clear.
module sys_ctrl_frame_timer
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned    CW   = tmo_cnt_w(TMO_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A clear in the expiry cycle suppresses the pulse: the arriving byte wins.
  always_comb begin
    expire = enable && !clear && (cnt_q == LAST);
    cnt_d  = cnt_q + CW'(1);
    if (clear || !enable || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sys_ctrl_rf.sv
// UART frame parser driving the register-file port: AA/addr/data writes,
// BB/addr reads whose answer is handed to the UART transmitter.
module sys_ctrl_rf
  import sys_ctrl_pkg::*;
#(
  parameter int                  WIDTH      = 8,
  parameter logic [WIDTH-1:0]    WR_CMD     = WIDTH'(WR_CMD_DEF),
  parameter logic [WIDTH-1:0]    RD_CMD     = WIDTH'(RD_CMD_DEF),
  parameter int unsigned         TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic          SC_CLK,
  input  logic          SC_RST,
  sys_ctrl_rf_if.slave  bus
);

  sc_state_e        state_q, state_d;
  logic [WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] txd_q, txd_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic             txv_q, txv_d;
  logic             err_q, err_d;
  logic             tmr_en, tmr_exp;

  assign tmr_en = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) ||
                  (state_q == S_RD_ADDR);

  sys_ctrl_frame_timer #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_frame_timer (
    .clk    (SC_CLK),
    .rst_n  (SC_RST),
    .clear  (bus.RX_D_VLD),
    .enable (tmr_en),
    .expire (tmr_exp)
  );

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    txd_d     = txd_q;
    txv_d     = txv_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == WR_CMD)      state_d = S_WR_ADDR;
          else if (bus.RX_P_DATA == RD_CMD) state_d = S_RD_ADDR;
          else                              err_d   = 1'b1;
        end
      end
      S_WR_ADDR: begin
        if (bus.RX_D_VLD) begin
          wr_addr_d = bus.RX_P_DATA;
          state_d   = S_WR_DATA;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_DATA: begin
        if (bus.RX_D_VLD) begin
          addr_d  = wr_addr_q;
          wdata_d = bus.RX_P_DATA;
          wr_en_d = 1'b1;
          state_d = S_IDLE;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          addr_d  = bus.RX_P_DATA;
          rd_en_d = 1'b1;
          state_d = S_RD_WAIT;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      // Bytes arriving while a read answer is outstanding are overruns.
      S_RD_WAIT: begin
        err_d = bus.RX_D_VLD;
        if (bus.RF_Rd_Data_Valid) begin
          txd_d   = bus.RF_RdData;
          txv_d   = 1'b1;
          state_d = S_TX_HOLD;
        end
      end
      S_TX_HOLD: begin
        err_d = bus.RX_D_VLD;
        if (txv_q && !bus.TX_BUSY) begin
          txv_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        txv_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge SC_CLK or negedge SC_RST) begin
    if (!SC_RST) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      txd_q     <= '0;
      txv_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      txd_q     <= txd_d;
      txv_q     <= txv_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      err_q     <= err_d;
    end
  end

  assign bus.RF_Addr   = addr_q;
  assign bus.RF_WrData = wdata_q;
  assign bus.RF_Wr_en  = wr_en_q;
  assign bus.RF_Rd_en  = rd_en_q;
  assign bus.TX_P_DATA = txd_q;
  assign bus.TX_D_VLD  = txv_q;
  assign bus.CMD_ERR   = err_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sys_ctrl_rf.sv
// Bench for sys_ctrl_rf: directed frames from the test plan followed by a
// random byte stream, checked cycle by cycle against a frame-level model.
module tb_sys_ctrl_rf;
  import sys_ctrl_pkg::*;

  localparam int         W   = 8;
  localparam int         TMO = 32;
  localparam logic [7:0] WR  = 8'hAA;
  localparam logic [7:0] RD  = 8'hBB;

  logic clk;
  logic rst_n;

  sys_ctrl_rf_if #(.WIDTH(W)) bus();

  sys_ctrl_rf #(
    .WIDTH      (W),
    .WR_CMD     (WR),
    .RD_CMD     (RD),
    .TMO_CYCLES (TMO)
  ) dut (
    .SC_CLK (clk),
    .SC_RST (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file environment ----------------
  function automatic logic [7:0] rf_init(input logic [7:0] a);
    if (a == 8'd2) return 8'h20;
    if (a == 8'd3) return 8'h08;
    return 8'h00;
  endfunction

  logic [7:0] rf_mem [256];
  logic       rf_vld;
  logic [7:0] rf_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) rf_mem[i] <= rf_init(8'(i));
      rf_vld   <= 1'b0;
      rf_rdata <= 8'h00;
    end else begin
      rf_vld <= bus.RF_Rd_en;
      if (bus.RF_Rd_en) rf_rdata <= rf_mem[bus.RF_Addr];
      if (bus.RF_Wr_en) rf_mem[bus.RF_Addr] <= bus.RF_WrData;
    end
  end

  assign bus.RF_Rd_Data_Valid = rf_vld;
  assign bus.RF_RdData        = rf_rdata;

  // ---------------- checking ----------------
  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [7:0] ref_rf [256];
  logic [7:0] frm [$];
  logic [7:0] exp_q [$];
  int         idle_cnt;
  bit         rd_busy;
  int         answer_in;
  logic [7:0] rd_addr;
  bit         e_wr, e_rd, e_err, e_txv;
  logic [7:0] e_addr, e_wd, e_txd;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_rf[i] = rf_init(8'(i));
    frm.delete();
    exp_q.delete();
    idle_cnt  = 0;
    rd_busy   = 0;
    answer_in = 0;
    rd_addr   = 8'h00;
    e_wr = 0; e_rd = 0; e_err = 0; e_txv = 0;
    e_addr = 8'h00; e_wd = 8'h00; e_txd = 8'h00;
  endtask

  // Predicts the outputs of the next cycle from this cycle's inputs.
  task automatic model_step(input bit v, input logic [7:0] b, input bit busy);
    e_wr = 0; e_rd = 0; e_err = 0;
    if (rd_busy) begin
      if (v) e_err = 1;
      if (answer_in > 0) begin
        answer_in--;
        if (answer_in == 0) begin
          e_txv = 1;
          e_txd = ref_rf[rd_addr];
          exp_q.push_back(e_txd);
        end
      end else if (!busy) begin
        e_txv   = 0;
        rd_busy = 0;
      end
    end else if (v) begin
      idle_cnt = 0;
      if (frm.size() == 0) begin
        if (b == WR || b == RD) frm.push_back(b);
        else                    e_err = 1;
      end else begin
        frm.push_back(b);
        if (frm[0] == WR && frm.size() == 3) begin
          e_wr = 1; e_addr = frm[1]; e_wd = frm[2];
          ref_rf[frm[1]] = frm[2];
          frm.delete();
        end else if (frm[0] == RD && frm.size() == 2) begin
          e_rd = 1; e_addr = frm[1]; rd_addr = frm[1];
          rd_busy = 1; answer_in = 2;
          frm.delete();
        end
      end
    end else if (frm.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == TMO) begin
        e_err = 1;
        idle_cnt = 0;
        frm.delete();
      end
    end
  endtask

  task automatic check_outputs();
    check("wr_en",   {7'b0, bus.RF_Wr_en}, {7'b0, e_wr});
    check("rd_en",   {7'b0, bus.RF_Rd_en}, {7'b0, e_rd});
    check("cmd_err", {7'b0, bus.CMD_ERR},  {7'b0, e_err});
    check("tx_vld",  {7'b0, bus.TX_D_VLD}, {7'b0, e_txv});
    check("rf_addr", bus.RF_Addr,   e_addr);
    check("rf_wdat", bus.RF_WrData, e_wd);
    check("tx_data", bus.TX_P_DATA, e_txd);
    if (frm.size() == 0 && !rd_busy)
      check("state_idle", {5'b0, bus.state_dbg}, {5'b0, ST_IDLE});
    if (rd_busy && answer_in == 0)
      check("state_tx_hold", {5'b0, bus.state_dbg}, {5'b0, ST_TX_HOLD});
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: checks this cycle, applies inputs, advances.
  task automatic tick(input bit v, input logic [7:0] b, input bit busy);
    logic [7:0] want;
    check_outputs();
    bus.RX_D_VLD  = v;
    bus.RX_P_DATA = v ? b : 8'($urandom);
    bus.TX_BUSY   = busy;
    if (bus.TX_D_VLD && !busy) begin
      check("tx_expected", {7'b0, exp_q.size() > 0}, 8'd1);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("tx_xfer_data", bus.TX_P_DATA, want);
      end
    end
    model_step(v, b, busy);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit busy);
    tick(1, b, busy);
    repeat (gap) tick(0, 8'h00, busy);
  endtask

  task automatic quiet(input int n, input bit busy);
    repeat (n) tick(0, 8'h00, busy);
  endtask

  task automatic do_reset();
    bus.RX_D_VLD = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_en",   {7'b0, bus.RF_Wr_en}, 8'd0);
    check("rst_rd_en",   {7'b0, bus.RF_Rd_en}, 8'd0);
    check("rst_cmd_err", {7'b0, bus.CMD_ERR},  8'd0);
    check("rst_tx_vld",  {7'b0, bus.TX_D_VLD}, 8'd0);
    check("rst_rf_addr", bus.RF_Addr,   8'd0);
    check("rst_rf_wdat", bus.RF_WrData, 8'd0);
    check("rst_tx_data", bus.TX_P_DATA, 8'd0);
    check("rst_state",   {5'b0, bus.state_dbg}, {5'b0, ST_IDLE});
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = 8'h00;
    bus.TX_BUSY   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // write then read back register 5
    send(WR, 10, 0); send(8'h05, 10, 0); send(8'h3C, 10, 0);
    send(RD, 10, 0); send(8'h05, 10, 0);

    // read with the transmitter stalled for 50 cycles
    send(RD, 3, 1); send(8'h02, 0, 1);
    quiet(53, 1);
    quiet(5, 0);

    // bad command, then a normal write
    send(8'h55, 3, 0);
    send(WR, 2, 0); send(8'h01, 2, 0); send(8'h7F, 3, 0);

    // timeout mid-write, then a stray byte in idle
    send(WR, 1, 0); send(8'h04, 0, 0);
    quiet(TMO + 3, 0);
    send(8'h04, 3, 0);

    // overrun during TX_HOLD
    send(RD, 2, 1); send(8'h03, 6, 1);
    send(WR, 4, 1);
    quiet(4, 0);

    // back-to-back write frames
    send(WR, 0, 0); send(8'h07, 0, 0); send(8'h11, 0, 0);
    send(WR, 0, 0); send(8'h07, 0, 0); send(8'h22, 2, 0);
    send(RD, 0, 0); send(8'h07, 6, 0);

    // reset mid-frame
    send(WR, 2, 0); send(8'h06, 2, 0);
    do_reset();
    send(8'h11, 4, 0);

    // random byte stream
    for (int i = 0; i < 5000; i++) begin
      bit         v;
      bit         busy;
      int         r;
      logic [7:0] b;
      v    = ($urandom_range(0, 2) == 0);
      busy = ($urandom_range(0, 3) == 0);
      r    = $urandom_range(0, 9);
      if (r < 3)      b = WR;
      else if (r < 6) b = RD;
      else if (r < 8) b = 8'($urandom_range(0, 7));
      else            b = 8'($urandom);
      tick(v, b, busy);
      if ($urandom_range(0, 99) == 0) quiet(TMO - 2 + $urandom_range(0, 4), busy);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    quiet(10, 0);
    check("tx_pending", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_rf.md
# sys_ctrl_rf

Command controller for the UART system's register file. It parses byte frames from the UART receiver into register-file write and read commands, and drives the register-file port. It returns read data to the UART transmitter. It sits between the UART RX/TX pair and the register file, and is the only initiator on the register-file port.

## Interface

Parameters:
- WIDTH, 8, width of data bytes, addresses and register contents
- WR_CMD, 8'hAA, command byte opening a write frame: CMD, ADDR, DATA
- RD_CMD, 8'hBB, command byte opening a read frame: CMD, ADDR
- TMO_CYCLES, 1024, inter-byte timeout in clock cycles; must be at least 2

Ports:
- SC_CLK  in  1  system clock; one clock, all logic on its rising edge
- SC_RST  in  1  reset, asynchronous, active-low
- RX_P_DATA  in  WIDTH  received byte; valid only while RX_D_VLD=1
- RX_D_VLD  in  1  one-cycle pulse per received byte
- RF_RdData  in  WIDTH  register-file read data
- RF_Rd_Data_Valid  in  1  register-file read data valid
- TX_BUSY  in  1  transmitter busy; the transmitter accepts a byte only when TX_BUSY=0
- RF_Addr  out  WIDTH  register-file address
- RF_WrData  out  WIDTH  register-file write data
- RF_Wr_en  out  1  register-file write strobe
- RF_Rd_en  out  1  register-file read strobe
- TX_P_DATA  out  WIDTH  byte to transmit
- TX_D_VLD  out  1  transmit request
- CMD_ERR  out  1  one-cycle error pulse

## Operation

- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_HOLD.
- IDLE transitions on RX_D_VLD:
  - byte = WR_CMD: go to WR_ADDR.
  - byte = RD_CMD: go to RD_ADDR.
  - any other byte: pulse CMD_ERR and stay in IDLE.
- WR_ADDR, on RX_D_VLD: latch the byte as the address and go to WR_DATA.
- WR_DATA, on RX_D_VLD: drive RF_Addr = latched address, RF_WrData = byte, RF_Wr_en=1 for exactly one cycle, then go to IDLE.
- RD_ADDR, on RX_D_VLD: drive RF_Addr = byte, RF_Rd_en=1 for exactly one cycle, then go to RD_WAIT.
- RD_WAIT, on RF_Rd_Data_Valid=1: load TX_P_DATA from RF_RdData and go to TX_HOLD.
- TX_HOLD:
  - TX_D_VLD=1 throughout; TX_P_DATA is held stable.
  - A cycle with TX_D_VLD=1 and TX_BUSY=0 is the transfer. The next cycle has TX_D_VLD=0 and the state is IDLE.
- RF_Wr_en and RF_Rd_en are never high in the same cycle.
- All outputs are registered.
- RF_Addr, RF_WrData and TX_P_DATA hold their last value between commands.
- A byte arriving in RD_WAIT or TX_HOLD is dropped (overrun): CMD_ERR pulses and the state is unchanged.
- Frame timeout:
  - The counter clears on every RX_D_VLD and counts only in WR_ADDR, WR_DATA and RD_ADDR.
  - After TMO_CYCLES consecutive cycles with no byte: go to IDLE and pulse CMD_ERR. No register-file strobe is issued.
  - If a byte and expiry coincide in the same cycle, the byte wins.
- RD_WAIT has no timeout, because the register file always answers in one cycle.

## Timing

- Reset values: every output is 0, the state is IDLE and the timeout counter is 0. Assertion takes effect immediately, mid-frame included, and aborts any partial command.
- Write: data byte at cycle n gives RF_Wr_en=1 in cycle n+1. The register is updated at the edge ending n+1.
- Read:
  - address byte at cycle n gives RF_Rd_en=1 in cycle n+1;
  - RF_Rd_Data_Valid=1 in cycle n+2;
  - TX_D_VLD=1 from cycle n+3;
  - with TX_BUSY=0, exactly one TX_D_VLD cycle.
- CMD_ERR is high for exactly one cycle, in the cycle after the offending byte or the expiry.
- Back-to-back frames: a WR_CMD byte arriving the cycle after a write's RF_Wr_en is accepted normally.

## Structure

- Shared package/include sys_ctrl_pkg holds:
  - the default WR_CMD and RD_CMD codes;
  - the FSM state encoding (3-bit localparams);
  - the timeout counter width, $clog2(TMO_CYCLES).
- One sub-module, sys_ctrl_frame_timer:
  - inputs: clear, enable;
  - output: one-cycle expire pulse;
  - parameter: TMO_CYCLES.
- The FSM, strobes and output registers stay in sys_ctrl_rf.

## Test plan

- Write frame: RX bytes AA, 05, 3C with 10-cycle gaps, then read frame BB, 05 -> RF_Wr_en one cycle with RF_Addr=05 and RF_WrData=3C. Later RF_Rd_en one cycle with RF_Addr=05, then TX_D_VLD with TX_P_DATA=3C exactly one cycle (TX_BUSY=0).
- Read while transmitter busy: BB, 02 with TX_BUSY=1 for 50 cycles -> TX_D_VLD held high with TX_P_DATA=20 (reset value of register 2) for 50 cycles, transfer in the first cycle TX_BUSY=0, then IDLE.
- Bad command: byte 55 in IDLE -> CMD_ERR one cycle, no strobes; a following AA, 01, 7F writes normally.
- Timeout: AA, 04, then silence TMO_CYCLES cycles -> CMD_ERR one cycle, no RF_Wr_en. A subsequent 04 byte in IDLE -> CMD_ERR, with no write.
- Overrun: BB, 03, then byte AA during TX_HOLD with TX_BUSY=1 -> CMD_ERR one cycle, TX_P_DATA=08 unchanged, state remains TX_HOLD.
- Reset mid-frame: AA, 06, assert SC_RST, release, then send 11 -> all outputs 0 during reset, no write, and 11 is treated as a bad command (CMD_ERR).
